// File: rtl/count_event_gen.sv
// Event detector for an upstream modulo counter: wrap, compare-match and an
// arm/ack notifier with overrun tracking. All outputs come straight from flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | notifier disabled; matches still pulse but are not latched
// ARMED   | waiting for the next qualified match
// PENDING | match latched, irq raised until ack
module count_event_gen #(
    parameter int MAX_COUNT  = 100,
    parameter int BIT_WIDTH  = $clog2(MAX_COUNT),
    parameter int WRAP_WIDTH = 8,
    parameter bit ONE_SHOT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIT_WIDTH-1:0]  count,
    input  logic                  cmpLoad,
    input  logic [BIT_WIDTH-1:0]  cmpIn,
    input  logic                  arm,
    input  logic                  ack,
    output logic                  matchPulse,
    output logic                  wrapPulse,
    output logic [WRAP_WIDTH-1:0] wrapCnt,
    output logic                  irq,
    output logic                  overrun,
    output logic                  armed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam logic [BIT_WIDTH-1:0] CMP_RESET = BIT_WIDTH'(MAX_COUNT - 1);

    state_t                state_q, state_d;
    logic [BIT_WIDTH-1:0]  prev_count_q, prev_count_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [BIT_WIDTH-1:0]  cmp_q, cmp_d;
    logic [WRAP_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                  match_pulse_q, match_pulse_d;
    logic                  wrap_pulse_q, wrap_pulse_d;
    logic                  irq_q, irq_d;
    logic                  overrun_q, overrun_d;
    logic                  armed_q, armed_d;

    logic wrap_det;
    logic match_det;

    always_comb begin
        wrap_det  = prev_valid_q && (count < prev_count_q);
        // A counter parked on the compare value must only match once.
        match_det = (count == cmp_q) && (!prev_valid_q || (count != prev_count_q));
    end

    always_comb begin
        prev_count_d  = count;
        prev_valid_d  = 1'b1;
        cmp_d         = cmpLoad ? cmpIn : cmp_q;
        match_pulse_d = match_det;
        wrap_pulse_d  = wrap_det;
        wrap_cnt_d    = wrap_cnt_q;
        if (wrap_det && (wrap_cnt_q != {WRAP_WIDTH{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (match_det) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (ack) begin
                    overrun_d = 1'b0;
                    if (ONE_SHOT) begin
                        state_d = IDLE;
                    end else if (match_det) begin
                        state_d = PENDING;
                    end else begin
                        state_d = ARMED;
                    end
                end else if (match_det) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                overrun_d = 1'b0;
            end
        endcase
        irq_d   = (state_d == PENDING);
        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_count_q  <= '0;
            prev_valid_q  <= 1'b0;
            cmp_q         <= CMP_RESET;
            wrap_cnt_q    <= '0;
            match_pulse_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            irq_q         <= 1'b0;
            overrun_q     <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_count_q  <= prev_count_d;
            prev_valid_q  <= prev_valid_d;
            cmp_q         <= cmp_d;
            wrap_cnt_q    <= wrap_cnt_d;
            match_pulse_q <= match_pulse_d;
            wrap_pulse_q  <= wrap_pulse_d;
            irq_q         <= irq_d;
            overrun_q     <= overrun_d;
            armed_q       <= armed_d;
        end
    end

    assign matchPulse = match_pulse_q;
    assign wrapPulse  = wrap_pulse_q;
    assign wrapCnt    = wrap_cnt_q;
    assign irq        = irq_q;
    assign overrun    = overrun_q;
    assign armed      = armed_q;

endmodule

// File: tb/tb_count_event_gen.sv
// Directed bench for count_event_gen: two instances (auto re-arm and one-shot)
// share stimulus; expectations are queued and checked by a separate monitor.
module tb_count_event_gen;

    localparam int MAXC = 100;
    localparam int BW   = $clog2(MAXC);
    localparam int WW   = 8;

    localparam int S_MATCH = 0, S_WRAP = 1, S_IRQ = 2, S_OVR = 3, S_ARMED = 4,
                   S_WCNT = 5, S_IRQB = 6, S_ARMEDB = 7, S_OVRB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] count = '0;
    logic [BW-1:0] cmp_in = '0;
    logic          cmp_load = 1'b0;
    logic          arm = 1'b0;
    logic          ack = 1'b0;

    logic          match_a, wrap_a, irq_a, ovr_a, armed_a;
    logic [WW-1:0] wcnt_a;
    logic          match_b, wrap_b, irq_b, ovr_b, armed_b;
    logic [WW-1:0] wcnt_b;

    count_event_gen #(.MAX_COUNT(MAXC), .BIT_WIDTH(BW), .WRAP_WIDTH(WW), .ONE_SHOT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .count(count), .cmpLoad(cmp_load), .cmpIn(cmp_in),
        .arm(arm), .ack(ack), .matchPulse(match_a), .wrapPulse(wrap_a),
        .wrapCnt(wcnt_a), .irq(irq_a), .overrun(ovr_a), .armed(armed_a));

    count_event_gen #(.MAX_COUNT(MAXC), .BIT_WIDTH(BW), .WRAP_WIDTH(WW), .ONE_SHOT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .count(count), .cmpLoad(cmp_load), .cmpIn(cmp_in),
        .arm(arm), .ack(ack), .matchPulse(match_b), .wrapPulse(wrap_b),
        .wrapCnt(wcnt_b), .irq(irq_b), .overrun(ovr_b), .armed(armed_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int obs(int sig);
        case (sig)
            S_MATCH:  return int'(match_a);
            S_WRAP:   return int'(wrap_a);
            S_IRQ:    return int'(irq_a);
            S_OVR:    return int'(ovr_a);
            S_ARMED:  return int'(armed_a);
            S_WCNT:   return int'(wcnt_a);
            S_IRQB:   return int'(irq_b);
            S_ARMEDB: return int'(armed_b);
            S_OVRB:   return int'(ovr_b);
            default:  return -1;
        endcase
    endfunction

    // Expectation for the outputs produced by the inputs of the current cycle.
    task automatic expect_nx(int sig, int val, string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(int c, bit ld = 1'b0, int ci = 0, bit a = 1'b0, bit k = 1'b0);
        count    = BW'(c);
        cmp_load = ld;
        cmp_in   = BW'(ci);
        arm      = a;
        ack      = k;
        @(posedge clk);
        #1;
    endtask

    task automatic run(int from, int to);
        for (int c = from; c <= to; c++) step(c);
    endtask

    task automatic expect_all_zero(string name);
        expect_nx(S_MATCH, 0, name);
        expect_nx(S_WRAP, 0, name);
        expect_nx(S_IRQ, 0, name);
        expect_nx(S_OVR, 0, name);
        expect_nx(S_ARMED, 0, name);
        expect_nx(S_WCNT, 0, name);
        expect_nx(S_IRQB, 0, name);
        expect_nx(S_ARMEDB, 0, name);
        expect_nx(S_OVRB, 0, name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (obs(e.sig) != e.val) begin
                errors++;
                $display("FAIL %s: cycle %0d sig %0d got %0d expected %0d",
                         e.name, cyc, e.sig, obs(e.sig), e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset
        rst = 1'b1;
        step(0);
        expect_all_zero("reset");
        step(0);
        rst = 1'b0;

        // Free-running roll-overs; reset compare value is 99
        for (int i = 0; i < 206; i++) begin
            int c;
            c = i % 100;
            if (i == 0) begin
                expect_nx(S_WRAP, 0, "first_sample_no_wrap");
                expect_nx(S_WCNT, 0, "first_sample_wcnt");
            end
            if (i == 99) begin
                expect_nx(S_MATCH, 1, "match_reset_cmp99");
                expect_nx(S_WRAP, 0, "no_wrap_at_99");
                expect_nx(S_IRQ, 0, "idle_match_no_irq");
            end
            if (i == 100) begin
                expect_nx(S_WRAP, 1, "wrap_first_rollover");
                expect_nx(S_WCNT, 1, "wcnt_1");
            end
            if (i == 101) begin
                expect_nx(S_WRAP, 0, "wrap_single_cycle");
                expect_nx(S_WCNT, 1, "wcnt_hold_1");
            end
            if (i == 200) begin
                expect_nx(S_WRAP, 1, "wrap_second_rollover");
                expect_nx(S_WCNT, 2, "wcnt_2");
            end
            step(c);
        end

        // cmpLoad timing: old value used in the load cycle, new one afterwards
        expect_nx(S_MATCH, 0, "cmpload_old_value");
        step(6, 1'b1, 6);
        expect_nx(S_MATCH, 0, "cmpload_second_load");
        step(7, 1'b1, 8);
        expect_nx(S_MATCH, 1, "cmpload_new_value");
        step(8);
        expect_nx(S_ARMED, 1, "arm_a");
        expect_nx(S_ARMEDB, 1, "arm_b");
        step(9, 1'b1, 59, 1'b1);
        run(10, 58);
        expect_nx(S_MATCH, 1, "match_59");
        expect_nx(S_IRQ, 1, "irq_59");
        expect_nx(S_ARMED, 0, "armed_drop_59");
        expect_nx(S_IRQB, 1, "irqb_59");
        expect_nx(S_OVR, 0, "no_overrun_59");
        step(59);
        expect_nx(S_IRQ, 0, "ack_irq_low");
        expect_nx(S_ARMED, 1, "ack_rearm");
        expect_nx(S_IRQB, 0, "ack_irqb_low");
        expect_nx(S_ARMEDB, 0, "oneshot_idle");
        expect_nx(S_MATCH, 0, "no_match_60");
        step(60, 1'b0, 0, 1'b0, 1'b1);

        // Backward load onto the compare value, then stall
        run(61, 80);
        expect_nx(S_WRAP, 1, "jump_wrap");
        expect_nx(S_MATCH, 1, "jump_match");
        expect_nx(S_IRQ, 1, "jump_irq");
        expect_nx(S_WCNT, 3, "wcnt_3");
        expect_nx(S_IRQB, 0, "idle_b_no_irq");
        step(59);
        for (int i = 0; i < 20; i++) begin
            expect_nx(S_MATCH, 0, "stall_no_match");
            expect_nx(S_WRAP, 0, "stall_no_wrap");
            step(59);
        end
        expect_nx(S_IRQ, 0, "stall_ack_irq");
        expect_nx(S_ARMED, 1, "stall_ack_armed");
        step(59, 1'b0, 0, 1'b0, 1'b1);

        // Overrun: two matches at 10 without ack
        expect_nx(S_ARMEDB, 1, "arm_b_again");
        expect_nx(S_ARMED, 1, "arm_ignored_a");
        step(59, 1'b1, 10, 1'b1);
        run(60, 99);
        expect_nx(S_WCNT, 4, "wcnt_4");
        step(0);
        run(1, 9);
        expect_nx(S_MATCH, 1, "ovr_match1");
        expect_nx(S_IRQ, 1, "ovr_irq1");
        expect_nx(S_IRQB, 1, "ovr_irqb1");
        expect_nx(S_OVR, 0, "ovr_not_yet");
        step(10);
        run(11, 99);
        expect_nx(S_WCNT, 5, "wcnt_5");
        step(0);
        run(1, 9);
        expect_nx(S_MATCH, 1, "ovr_match2");
        expect_nx(S_IRQ, 1, "ovr_irq_held");
        expect_nx(S_OVR, 1, "ovr_set");
        expect_nx(S_OVRB, 1, "ovrb_set");
        step(10);
        expect_nx(S_IRQ, 0, "ovr_ack_irq");
        expect_nx(S_OVR, 0, "ovr_ack_clear");
        expect_nx(S_ARMED, 1, "ovr_ack_rearm");
        expect_nx(S_IRQB, 0, "ovr_ack_irqb");
        expect_nx(S_OVRB, 0, "ovr_ack_clear_b");
        expect_nx(S_ARMEDB, 0, "ovr_ack_idle_b");
        step(11, 1'b0, 0, 1'b0, 1'b1);

        // ack coincident with a new match while PENDING
        expect_nx(S_ARMEDB, 1, "arm_b_third");
        step(12, 1'b0, 0, 1'b1);
        run(13, 99);
        step(0);
        run(1, 9);
        expect_nx(S_IRQ, 1, "coin_irq");
        expect_nx(S_IRQB, 1, "coin_irqb");
        step(10);
        step(11);
        expect_nx(S_OVR, 1, "coin_pre_overrun");
        expect_nx(S_WCNT, 7, "wcnt_7");
        step(10);
        step(11);
        expect_nx(S_MATCH, 1, "coin_match");
        expect_nx(S_IRQ, 1, "coin_irq_stays");
        expect_nx(S_OVR, 0, "coin_overrun_clear");
        expect_nx(S_ARMED, 0, "coin_not_armed");
        expect_nx(S_IRQB, 0, "coin_oneshot_irq");
        expect_nx(S_ARMEDB, 0, "coin_oneshot_idle");
        expect_nx(S_OVRB, 0, "coin_oneshot_ovr");
        step(10, 1'b0, 0, 1'b0, 1'b1);

        // Reset mid-operation
        step(11);
        expect_nx(S_OVR, 1, "pre_rst_overrun");
        expect_nx(S_WCNT, 9, "pre_rst_wcnt");
        step(10);
        rst = 1'b1;
        expect_all_zero("midrun_reset");
        step(12);
        rst = 1'b0;
        expect_nx(S_WRAP, 0, "post_rst_no_wrap");
        expect_nx(S_MATCH, 0, "post_rst_no_match");
        step(0);
        run(1, 98);
        expect_nx(S_MATCH, 1, "post_rst_cmp99");
        step(99);
        expect_nx(S_WRAP, 1, "post_rst_wrap");
        expect_nx(S_WCNT, 1, "post_rst_wcnt");
        step(0);

        // wrapCnt saturation
        for (int k = 1; k <= 300; k++) begin
            step(1);
            if (k == 253) expect_nx(S_WCNT, 254, "wcnt_254");
            if (k == 254) expect_nx(S_WCNT, 255, "wcnt_255");
            if (k == 300) begin
                expect_nx(S_WCNT, 255, "wcnt_saturated");
                expect_nx(S_WRAP, 1, "wrap_at_saturation");
            end
            step(0);
        end

        step(0);
        step(0);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
